// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the IRAM readout path.
package lcd_pkg;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int SUM_W  = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_e;
endpackage

// File: rtl/readout_skid_buf.sv
// Two-entry FIFO between the IRAM read port and the pixel stream.
// Head is shown combinationally; count tells the reader how much room is left.
module readout_skid_buf #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [1:0]       count_o
);
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (clr_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/iram_readout.sv
// Streams the 64 processed pixels out of IRAM after the LCD controller finishes,
// with credit-based read issue so a stalled consumer never loses data.
module iram_readout
   import lcd_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              done,
   output logic              iram_sel,
   output logic              IRAM_ceb,
   output logic              IRAM_web,
   output logic [ADDR_W-1:0] IRAM_A,
   input  logic [DATA_W-1:0] IRAM_Q,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic [SUM_W-1:0]  checksum,
   output logic              checksum_valid,
   output logic              busy
);
   state_e            state_q, state_d;
   logic              done_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic              start, issue, pop, clr;
   logic [1:0]        buf_count;
   logic [DATA_W:0]   head;
   logic [2:0]        credit_used;

   assign start = (state_q == IDLE) && done && !done_q;
   assign pop   = pix_valid && pix_ready;
   // A pop this cycle frees a slot in time for the data of a read issued now.
   assign credit_used = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      sum_d           = sum_q;
      issue           = 1'b0;
      clr             = 1'b0;
      iram_sel        = 1'b0;
      busy            = 1'b0;
      checksum_valid  = 1'b0;
      if (pop) sum_d = sum_q + SUM_W'(pix_data);
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               addr_d  = '0;
               sum_d   = '0;
               clr     = 1'b1;
            end
         end
         READ: begin
            iram_sel = 1'b1;
            busy     = 1'b1;
            issue    = (credit_used < 3'd2);
            if (issue) begin
               addr_d          = addr_q + ADDR_W'(1);
               inflight_d      = 1'b1;
               inflight_last_d = (addr_q == ADDR_W'(DEPTH - 1));
               if (addr_q == ADDR_W'(DEPTH - 1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            iram_sel = 1'b1;
            busy     = 1'b1;
            if (pop && pix_last) state_d = FIN;
         end
         FIN: begin
            checksum_valid = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         done_q          <= 1'b0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         sum_q           <= '0;
      end else begin
         state_q         <= state_d;
         done_q          <= done;
         addr_q          <= addr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         sum_q           <= sum_d;
      end
   end

   readout_skid_buf #(
      .WIDTH (DATA_W + 1)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clr),
      .push_i      (inflight_q),
      .push_data_i ({inflight_last_q, IRAM_Q}),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (buf_count)
   );

   assign IRAM_ceb  = ~issue;
   assign IRAM_web  = 1'b1;
   assign IRAM_A    = addr_q;
   assign pix_valid = (buf_count != 2'd0);
   assign pix_data  = head[DATA_W-1:0];
   assign pix_last  = pix_valid && head[DATA_W];
   assign checksum  = sum_q;
endmodule

// File: tb/tb_iram_readout.sv
// Directed bench for iram_readout: IRAM model, frame runner and scalar checks.
module tb_iram_readout;
   import lcd_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              done;
   logic              iram_sel;
   logic              IRAM_ceb;
   logic              IRAM_web;
   logic [ADDR_W-1:0] IRAM_A;
   logic [DATA_W-1:0] IRAM_Q;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_last;
   logic [SUM_W-1:0]  checksum;
   logic              checksum_valid;
   logic              busy;

   iram_readout dut (
      .clk            (clk),
      .rst            (rst),
      .done           (done),
      .iram_sel       (iram_sel),
      .IRAM_ceb       (IRAM_ceb),
      .IRAM_web       (IRAM_web),
      .IRAM_A         (IRAM_A),
      .IRAM_Q         (IRAM_Q),
      .pix_data       (pix_data),
      .pix_valid      (pix_valid),
      .pix_ready      (pix_ready),
      .pix_last       (pix_last),
      .checksum       (checksum),
      .checksum_valid (checksum_valid),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] iram_mem [DEPTH];
   always @(posedge clk) if (!IRAM_ceb) IRAM_Q <= iram_mem[IRAM_A];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Results of the most recent run_frame
   int beats, cv_n, cv_cyc, first_v, lastn, last_idx, stall_err, order_err, n_early, busy_start;
   logic [ADDR_W-1:0] early_a [2];
   logic [SUM_W-1:0]  cv_sum;

   // mode 0: ready=1, 1: random ready, 2: ready=0 for first 20 cycles
   task automatic run_frame(input int mode, input bit hold_done, input int abort_beat, input int redone_beat);
      bit               prev_stall;
      logic [DATA_W-1:0] prev_data;
      beats = 0; cv_n = 0; cv_cyc = -1; first_v = -1; lastn = 0; last_idx = -1;
      stall_err = 0; order_err = 0; n_early = 0; busy_start = 0; cv_sum = '0;
      early_a[0] = '0; early_a[1] = '0;
      prev_stall = 1'b0; prev_data = '0;
      @(negedge clk);
      done = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (cyc == 0 && !hold_done) done = 1'b0;
         if (redone_beat >= 0 && beats == redone_beat) done = 1'b1;
         if (redone_beat >= 0 && beats == redone_beat + 5) done = 1'b0;
         case (mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = (cyc >= 20);
         endcase
         #1;
         if (cyc == 0) busy_start = int'(busy);
         if (prev_stall && (!pix_valid || pix_data != prev_data)) stall_err++;
         if (!IRAM_ceb && cyc < 20) begin
            if (n_early < 2) early_a[n_early] = IRAM_A;
            n_early++;
         end
         if (pix_valid && first_v < 0) first_v = cyc;
         if (checksum_valid) begin
            cv_n++;
            cv_cyc = cyc;
            cv_sum = checksum;
         end
         if (pix_valid && pix_ready) begin
            if (beats >= DEPTH || pix_data != iram_mem[beats]) order_err++;
            if (pix_last) begin
               lastn++;
               last_idx = beats;
            end
            beats++;
         end
         prev_stall = pix_valid && !pix_ready;
         prev_data  = pix_data;
         if (abort_beat >= 0 && beats == abort_beat) begin
            rst = 1'b0;
            #1;
            return;
         end
         if (cv_n > 0 && cyc >= cv_cyc + 4) break;
      end
      $display("frame mode=%0d beats=%0d checksum=%0d cv_pulses=%0d cv_cycle=%0d", mode, beats, cv_sum, cv_n, cv_cyc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_iram_sel"}, iram_sel, 0);
      check({tag, "_ceb"}, IRAM_ceb, 1);
      check({tag, "_web"}, IRAM_web, 1);
      check({tag, "_addr"}, IRAM_A, 0);
      check({tag, "_valid"}, pix_valid, 0);
      check({tag, "_last"}, pix_last, 0);
      check({tag, "_data"}, pix_data, 0);
      check({tag, "_checksum"}, checksum, 0);
      check({tag, "_cv"}, checksum_valid, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic check_full_frame(input string tag, input int exp_sum);
      check({tag, "_beats"}, beats, 64);
      check({tag, "_order"}, order_err, 0);
      check({tag, "_last_n"}, lastn, 1);
      check({tag, "_last_idx"}, last_idx, 63);
      check({tag, "_cv_pulses"}, cv_n, 1);
      check({tag, "_sum"}, cv_sum, exp_sum);
   endtask

   initial begin
      int busy_seen, cv_seen, rd_seen;
      rst = 1'b0; done = 1'b0; pix_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) iram_mem[i] = DATA_W'(i);
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Ramp image, consumer always ready
      run_frame(0, 1'b0, -1, -1);
      check_full_frame("ramp", 2016);
      check("ramp_first_valid_cyc", first_v, 2);
      check("ramp_cv_cyc", cv_cyc, 66);
      check("ramp_busy_start", busy_start, 1);
      check("ramp_stall", stall_err, 0);
      check("ramp_sum_hold", checksum, 2016);
      check("ramp_busy_idle", busy, 0);
      check("ramp_sel_idle", iram_sel, 0);

      // Saturated pixels, random backpressure
      for (int i = 0; i < DEPTH; i++) iram_mem[i] = 8'hFF;
      run_frame(1, 1'b0, -1, -1);
      check_full_frame("sat", 16320);
      check("sat_stall", stall_err, 0);

      // Consumer stalled for 20 cycles after start
      for (int i = 0; i < DEPTH; i++) iram_mem[i] = DATA_W'(i);
      run_frame(2, 1'b0, -1, -1);
      check("stall_reads", n_early, 2);
      check("stall_addr0", early_a[0], 0);
      check("stall_addr1", early_a[1], 1);
      check("stall_hold", stall_err, 0);
      check_full_frame("stall", 2016);

      // done held high: exactly one frame, then a fresh edge restarts from zero
      run_frame(0, 1'b1, -1, -1);
      check("hold_cv_pulses", cv_n, 1);
      busy_seen = 0; cv_seen = 0; rd_seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (checksum_valid) cv_seen++;
         if (!IRAM_ceb) rd_seen++;
      end
      check("hold_no_busy", busy_seen, 0);
      check("hold_no_cv", cv_seen, 0);
      check("hold_no_reads", rd_seen, 0);
      done = 1'b0;
      run_frame(0, 1'b0, -1, -1);
      check_full_frame("retrig", 2016);

      // Asynchronous reset mid-frame, then a clean frame
      run_frame(0, 1'b0, 30, -1);
      check("abort_beats", beats, 30);
      check_reset_outputs("abort");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run_frame(0, 1'b0, -1, -1);
      check_full_frame("after_rst", 2016);
      check("after_rst_first_valid", first_v, 2);

      // Extra done edge during a frame is ignored
      run_frame(0, 1'b0, -1, 10);
      check_full_frame("redone", 2016);
      check("redone_cv_cyc", cv_cyc, 66);
      repeat (5) @(negedge clk);
      check("redone_idle_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
